// File: rtl/int_controller.sv
// Seven-source interrupt controller with mask, routing and priority vector.
// Edge-triggered pending latch when INTC_EDGE_EN is defined, level mode otherwise.
module int_controller (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CS,
   input  logic [1:0]  ADDR,
   input  logic [15:0] DIN,
   output logic [15:0] DOUT,
   input  logic        RDN,
   input  logic        WR0N,
   input  logic        WR1N,
   input  logic [6:0]  INTS,
   output logic        INT0,
   output logic        INT1
);

   logic [6:0]  s1_q, s2_q;
   logic [6:0]  mask_q, mask_d;
   logic [6:0]  route_q, route_d;
   logic [6:0]  pend_q, pend_d;
   logic        int0_q, int0_d;
   logic        int1_q, int1_d;
   logic [6:0]  pm_w;
   logic [15:0] vec_w;
   logic        wr_en;
   logic        unused_w;

   assign unused_w = ^{WR1N, DIN[15:7]};
   assign wr_en    = CS & ~WR0N;
   assign pm_w     = pend_q & mask_q;

`ifdef INTC_EDGE_EN
   logic [6:0] s3_q;
   logic [6:0] clr_w;

   assign clr_w = (wr_en && ADDR == 2'd1) ? DIN[6:0] : 7'd0;

   always_ff @(posedge CLK) begin
      if (RESET) s3_q <= '0;
      else       s3_q <= s2_q;
   end

   // A fresh edge wins over a same-cycle clear of that bit.
   always_comb begin
      pend_d = (pend_q & ~clr_w) | (s2_q & ~s3_q);
   end
`else
   always_comb begin
      pend_d = s2_q;
   end
`endif

   always_comb begin
      mask_d  = mask_q;
      route_d = route_q;
      if (wr_en && ADDR == 2'd0) mask_d  = DIN[6:0];
      if (wr_en && ADDR == 2'd3) route_d = DIN[6:0];
      int0_d = |(pend_q & mask_q & ~route_q);
      int1_d = |(pend_q & mask_q & route_q);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         s1_q    <= '0;
         s2_q    <= '0;
         mask_q  <= '0;
         route_q <= '0;
         pend_q  <= '0;
         int0_q  <= 1'b0;
         int1_q  <= 1'b0;
      end else begin
         s1_q    <= INTS;
         s2_q    <= s1_q;
         mask_q  <= mask_d;
         route_q <= route_d;
         pend_q  <= pend_d;
         int0_q  <= int0_d;
         int1_q  <= int1_d;
      end
   end

   // Scan downward so the lowest-numbered active bit is the one kept.
   always_comb begin
      vec_w = 16'h8000;
      for (int i = 6; i >= 0; i--) begin
         if (pm_w[i]) vec_w = {13'd0, 3'(i)};
      end
   end

   always_comb begin
      DOUT = 16'h0000;
      if (CS && !RDN) begin
         unique case (ADDR)
            2'd0: DOUT = {9'd0, mask_q};
            2'd1: DOUT = {9'd0, pend_q};
            2'd2: DOUT = vec_w;
            2'd3: DOUT = {9'd0, route_q};
            default: DOUT = 16'h0000;
         endcase
      end
   end

   assign INT0 = int0_q;
   assign INT1 = int1_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed and random checks of int_controller against a register-level model.
// Define INTC_EDGE_EN for both bench and RTL to exercise edge mode.
module tb_int_controller;

   logic        clk = 1'b0;
   logic        reset, cs, rdn, wr0n, wr1n;
   logic [1:0]  addr;
   logic [15:0] din;
   logic [15:0] dout;
   logic [6:0]  ints;
   logic        int0, int1;

   int checks = 0;
   int errors = 0;

   // Model: input sample history, register file and registered outputs.
   logic [6:0] m_sync [3];
   logic [6:0] m_mask, m_route, m_pend;
   logic       m_int0, m_int1;

   int_controller dut (
      .CLK(clk), .RESET(reset), .CS(cs), .ADDR(addr), .DIN(din),
      .DOUT(dout), .RDN(rdn), .WR0N(wr0n), .WR1N(wr1n),
      .INTS(ints), .INT0(int0), .INT1(int1)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] m_vec(input logic [6:0] pm);
      for (int i = 0; i < 7; i++) if (pm[i]) return {13'd0, 3'(i)};
      return 16'h8000;
   endfunction

   function automatic logic [15:0] m_dout();
      if (!(cs && !rdn)) return 16'h0000;
      case (addr)
         2'd0: return {9'd0, m_mask};
         2'd1: return {9'd0, m_pend};
         2'd2: return m_vec(m_pend & m_mask);
         default: return {9'd0, m_route};
      endcase
   endfunction

   task automatic tick();
      logic [6:0] np;
      logic       wr;
      wr = cs && !wr0n;
      if (reset) begin
         for (int i = 0; i < 3; i++) m_sync[i] = '0;
         m_mask = '0; m_route = '0; m_pend = '0;
         m_int0 = 0;  m_int1 = 0;
      end else begin
`ifdef INTC_EDGE_EN
         np = m_pend & ~((wr && addr == 2'd1) ? din[6:0] : 7'd0);
         np = np | (m_sync[1] & ~m_sync[2]);
`else
         np = m_sync[1];
`endif
         m_int0 = |(m_pend & m_mask & ~m_route);
         m_int1 = |(m_pend & m_mask & m_route);
         if (wr && addr == 2'd0) m_mask  = din[6:0];
         if (wr && addr == 2'd3) m_route = din[6:0];
         m_sync[2] = m_sync[1];
         m_sync[1] = m_sync[0];
         m_sync[0] = ints;
         m_pend = np;
      end
      @(posedge clk);
      #1;
      chk("int0", 16'(int0), 16'(m_int0));
      chk("int1", 16'(int1), 16'(m_int1));
      chk("dout", dout, m_dout());
   endtask

   task automatic wr(input logic [1:0] a, input logic [6:0] d);
      cs = 1; wr0n = 0; addr = a; din = {9'd0, d};
      tick();
      cs = 0; wr0n = 1; din = '0;
   endtask

   task automatic rd(input string tag, input logic [1:0] a,
                     input logic [15:0] exp);
      cs = 1; rdn = 0; addr = a;
      #1;
      chk(tag, dout, exp);
      cs = 0; rdn = 1;
   endtask

   initial begin
      int cnt, first;
      for (int i = 0; i < 3; i++) m_sync[i] = '0;
      m_mask = '0; m_route = '0; m_pend = '0; m_int0 = 0; m_int1 = 0;
      reset = 1; cs = 0; rdn = 1; wr0n = 1; wr1n = 1;
      addr = '0; din = '0; ints = '0;
      tick();
      tick();
      reset = 0;
      chk("rst_int0", 16'(int0), 16'h0);
      chk("rst_int1", 16'(int1), 16'h0);
      rd("rst_mask", 2'd0, 16'h0000);
      rd("rst_pend", 2'd1, 16'h0000);
      rd("rst_vec",  2'd2, 16'h8000);

`ifdef INTC_EDGE_EN
      wr(2'd0, 7'h04);
      wr(2'd3, 7'h00);
      cs = 1; rdn = 0; addr = 2'd1; ints = 7'h04;
      tick(); tick(); tick();
      chk("edge_pend", dout, 16'h0004);
      tick();
      chk("edge_int0", 16'(int0), 16'h1);
      chk("edge_int1", 16'(int1), 16'h0);
      addr = 2'd2; #1;
      chk("edge_vec", dout, 16'h0002);
      cs = 0; rdn = 1; ints = 0;
      wr(2'd1, 7'h7F);

      wr(2'd0, 7'h7F);
      wr(2'd3, 7'h01);
      ints = 7'h21; tick(); ints = 0;
      repeat (4) tick();
      chk("route_int1", 16'(int1), 16'h1);
      chk("route_int0", 16'(int0), 16'h1);
      rd("route_vec0", 2'd2, 16'h0000);
      wr(2'd1, 7'h01);
      tick();
      chk("route_int1_clr", 16'(int1), 16'h0);
      rd("route_vec5", 2'd2, 16'h0005);

      wr(2'd1, 7'h7F);
      ints = 7'h08; tick(); tick();
      wr(2'd1, 7'h08);
      rd("set_wins", 2'd1, 16'h0008);

      wr(2'd1, 7'h7F);
      wr(2'd0, 7'h00);
      ints = 7'h18; repeat (3) tick();
      rd("masked_vec",  2'd2, 16'h8000);
      rd("masked_pend", 2'd1, 16'h0010);
      chk("masked_int0", 16'(int0), 16'h0);
      chk("masked_int1", 16'(int1), 16'h0);
      wr(2'd0, 7'h10);
      tick();
      chk("unmask_int0", 16'(int0), 16'h1);

      ints = 0; repeat (3) tick();
      ints = 7'h7F; repeat (3) tick();
      wr(2'd0, 7'h7F);
      wr(2'd3, 7'h00);
      tick();
      chk("pre_rst_int0", 16'(int0), 16'h1);
      rd("pre_rst_pend", 2'd1, 16'h007F);
      reset = 1; tick(); reset = 0;
      chk("mid_rst_int0", 16'(int0), 16'h0);
      rd("mid_rst_mask", 2'd0, 16'h0000);
      rd("mid_rst_pend", 2'd1, 16'h0000);
      repeat (4) tick();
      rd("rst_new_edge", 2'd1, 16'h007F);
`else
      wr(2'd0, 7'h02);
      wr(2'd3, 7'h00);
      cnt = 0; first = -1;
      ints = 7'h02;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) ints = 7'h00;
         tick();
         if (int0) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      chk("level_cnt",   16'(cnt),   16'd5);
      chk("level_first", 16'(first), 16'd3);
      ints = 7'h40; repeat (3) tick();
      wr(2'd1, 7'h7F);
      rd("level_noclr", 2'd1, 16'h0040);
      ints = 0;
`endif

      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) ints = 7'($urandom);
         cs   = 1'($urandom);
         rdn  = 1'($urandom);
         wr0n = 1'($urandom);
         wr1n = 1'($urandom);
         addr = 2'($urandom);
         din  = 16'($urandom);
         tick();
      end
      reset = 0; cs = 0; rdn = 1; wr0n = 1; wr1n = 1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have: RESET  in  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-003 SHALL have: CS  in  1  register-block select, decoded from the CPU address bus.
REQ-004 SHALL have: ADDR  in  2  register index: 0 MASK, 1 PENDING, 2 VECTOR, 3 ROUTE.
REQ-005 SHALL have: DIN  in  16  CPU write data; only [6:0] used.
REQ-006 SHALL have: DOUT  out  16  read data.
REQ-007 SHALL have: RDN  in  1  active-low read strobe.
REQ-008 SHALL have: WR0N  in  1  active-low low-byte write strobe; the only strobe that writes registers.
REQ-009 SHALL have: WR1N  in  1  active-low high-byte write strobe; ignored.
REQ-010 SHALL have: INTS  in  7  asynchronous interrupt sources; bit 0 has highest priority.
REQ-011 SHALL have: INT0  out  1  registered, active-high interrupt request to the CPU core, line 0.
REQ-012 SHALL have: INT1  out  1  registered, active-high interrupt request to the CPU core, line 1.

Function
REQ-013 SHALL pass each INTS bit through a two-flop synchronizer (s1, s2) and keep s2 of the previous cycle (s3) for edge detection.
REQ-014 SHALL set PENDING[i] on the cycle where s2[i]=1 and s3[i]=0. INTS high first sampled at edge k gives PENDING set at edge k+2 and INT asserted at edge k+3.
REQ-015 SHALL write MASK[6:0]=DIN[6:0] on every cycle where CS=1, WR0N=0 and ADDR=0.
REQ-016 SHALL write ROUTE[6:0]=DIN[6:0] on every cycle where CS=1, WR0N=0 and ADDR=3.
REQ-017 SHALL clear PENDING bits where DIN=1 (write-1-to-clear) on writes to ADDR=1. Repeated strobe cycles are idempotent.
REQ-018 SHALL give priority to set over clear when a new edge and a clear of the same bit occur in the same cycle; the bit remains 1.
REQ-019 SHALL treat writes to ADDR=2 as no effect.
REQ-020 SHALL register INT0 = |(PENDING & MASK & ~ROUTE) and INT1 = |(PENDING & MASK & ROUTE) each cycle.
REQ-021 SHALL encode VECTOR combinationally as follows:
- bits [2:0] = index of the lowest-numbered bit of PENDING & MASK;
- bit 15 = 1 when no such bit exists (with [2:0]=0);
- all other bits = 0.
REQ-022 SHALL drive DOUT combinationally when CS=1 and RDN=0: the selected register zero-extended to 16 bits (VECTOR as per REQ-021). Otherwise DOUT SHALL be 16'h0000.
REQ-023 SHALL not alter any state on reads; read and write in the same cycle returns the pre-write value.
REQ-024 SHALL leave masked pending bits latched, so that unmasking later raises INT one cycle after the MASK write edge.

Reset
REQ-025 SHALL on RESET=1 clear, at the next edge:
- s1, s2, s3;
- MASK, PENDING, ROUTE;
- INT0, INT1.
While RESET is held, INT0=INT1=0 and DOUT follows REQ-022.
REQ-026 SHALL treat a source already high when RESET deasserts as a new edge, setting PENDING two cycles after release.
REQ-027 SHALL give RESET priority over any concurrent write or edge.

Configuration
REQ-028 SHALL, with INTC_EDGE_EN defined, behave edge-triggered as REQ-013..018.
REQ-029 SHALL, without INTC_EDGE_EN, operate in level mode:
- PENDING = s2 every cycle;
- writes to ADDR=1 have no effect;
- s3 is not implemented.

Verification
REQ-030 SHALL cover edge set: with INTC_EDGE_EN defined and MASK=7'h04, ROUTE=0, raise INTS[2] at edge k -> PENDING=7'h04 at k+2, INT0=1 at k+3, INT1=0, VECTOR=16'h0002.
REQ-031 SHALL cover routing: with MASK=7'h7F and ROUTE=7'h01, pulse INTS[0] and INTS[5] -> INT1=1, INT0=1, VECTOR=16'h0000. Then write 7'h01 to PENDING -> INT1=0 one cycle later and VECTOR=16'h0005.
REQ-032 SHALL cover set-versus-clear: issue an edge on INTS[3] in the same cycle as a write of 7'h08 to ADDR=1 -> PENDING[3] remains 1.
REQ-033 SHALL cover empty and masked state: with MASK=0 and PENDING=7'h10 -> VECTOR=16'h8000 and INT0=INT1=0. Then write MASK=7'h10 -> INT0=1 one cycle later.
REQ-034 SHALL cover reset mid-operation: with INT0=1 and PENDING=7'h7F, assert RESET for one cycle -> all registers 0 and INT0=0 next edge, and DOUT=16'h0000 on a subsequent MASK read.
REQ-035 SHALL cover level mode: without INTC_EDGE_EN and MASK=7'h02, hold INTS[1] high for 5 cycles then drop -> INT0 is high for 5 cycles, lagging the input by 3 edges.
